// File: rtl/serial_shift_tx.sv
// serial_shift_tx: parallel-in / serial-out transmitter with a registered
// complementary serial line (s / s_n). A word is taken through a valid/ready
// handshake and shifted out one bit per clock, back-to-back frames allowed.
// Optional feature macro: PARITY_EN appends one even-parity bit per frame.
module serial_shift_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s,
    output logic             s_n,
    output logic             busy,
    output logic             first,
    output logic             last
);

`ifdef PARITY_EN
    localparam int N = WIDTH + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    localparam int N = WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             s_q, sn_q;
    logic             bit_nxt;
    logic             accept;
`ifdef PARITY_EN
    logic             par_q;
`endif

    // Bit that leaves the word first, in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the head bit consumed, zero filled from the far end.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
        else           return {1'b0, w[WIDTH-1:1]};
    endfunction

    assign busy       = (state != IDLE);
    assign first      = busy && (cnt == '0);
    assign last       = busy && (cnt == LAST_CNT);
    assign load_ready = (state == IDLE) || last;
    assign accept     = load_valid && load_ready;
    assign s          = s_q;
    assign s_n        = sn_q;

    // State register; an asserted reset aborts any frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a load is only taken when idle or on the final bit of a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: begin
                if (cnt == DATA_LAST) begin
`ifdef PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: state_nxt = accept ? SHIFT : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Next bit, remaining word and bit position for the coming cycle.
    always_comb begin
        bit_nxt  = IDLE_LEVEL;
        sreg_nxt = sreg;
        cnt_nxt  = '0;
        if (accept) begin
            bit_nxt  = head_bit(data);
            sreg_nxt = drop_head(data);
        end else if (state_nxt == SHIFT) begin
            bit_nxt  = head_bit(sreg);
            sreg_nxt = drop_head(sreg);
            cnt_nxt  = cnt + CW'(1);
`ifdef PARITY_EN
        end else if (state_nxt == PARITY) begin
            bit_nxt  = par_q;
            cnt_nxt  = cnt + CW'(1);
`endif
        end
    end

    // Datapath registers: serial line pair, remaining word, bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
            s_q  <= IDLE_LEVEL;
            sn_q <= ~IDLE_LEVEL;
        end else begin
            sreg <= sreg_nxt;
            cnt  <= cnt_nxt;
            s_q  <= bit_nxt;
            sn_q <= ~bit_nxt;
        end
    end

`ifdef PARITY_EN
    // Even parity of the accepted word, sent after its last data bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      par_q <= 1'b0;
        else if (accept) par_q <= ^data;
    end
`endif

endmodule
